// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - logic-analyzer acquisition sequencer feeding the sample RAM write port
//
// Purpose:
//   Arms an acquisition, paces sampling with a clock prescaler, and writes samples into the
//   sample RAM as a ring. It hands over to post-trigger capture when i_run rises, and it stops
//   after a programmed post-trigger depth or when i_run falls.
//
// Optional feature macro: CAPTURE_PRETRIG_EN
//   defined     - ARMED ring-writes pre-trigger samples.
//   not defined - ARMED does no writes. Capture starts at address 0 and o_wrapped stays 0.
//
// Ports:
//   clk             system clock, rising edge
//   internal_reset  synchronous active-high reset
//   i_cfg_div       sample period - 1 (0 = every clk), latched on arm
//   i_cfg_depth     post-trigger sample count (0 = 2**ADDR_W), latched on arm
//   i_arm           start acquisition from IDLE/DONE
//   i_abort         cancel acquisition, return to IDLE
//   i_run           run level from channel_trigger
//   i_data          live channel data
//   o_mem_we        RAM write enable
//   o_mem_addr      RAM write address
//   o_mem_wdata     RAM write data
//   o_trig_addr     RAM address of first post-trigger sample
//   o_wrapped       pre-trigger ring wrapped at least once
//   o_busy          state is ARMED or CAPTURE
//   o_done          state is DONE
//   o_state         IDLE=0 ARMED=1 CAPTURE=2 DONE=3
module capture_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              internal_reset,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [ADDR_W-1:0] i_cfg_depth,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_run,
  input  logic [WIDTH-1:0]  i_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_wdata,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_wrapped,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_l;
  logic [DIV_W-1:0]  presc_cnt;
  logic [ADDR_W-1:0] depth_l;
  logic [ADDR_W-1:0] wr_addr;
  // The post counter is one bit wider so that a full-ring depth (depth_l == 0) is reachable.
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   post_target;
  logic [ADDR_W:0]   post_next;
  logic              run_state;
  logic              tick;
  logic              depth_hit;

`ifdef CAPTURE_PRETRIG_EN
  assign run_state = (state == S_ARMED) || (state == S_CAPTURE);
`else
  assign run_state = (state == S_CAPTURE);
`endif

  assign tick        = run_state && (presc_cnt == div_l);
  assign post_target = (depth_l == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, depth_l};
  assign post_next   = post_cnt + (ADDR_W+1)'(tick);
  assign depth_hit   = tick && (post_next == post_target);

  assign o_busy  = (state == S_ARMED) || (state == S_CAPTURE);
  assign o_done  = (state == S_DONE);
  assign o_state = state;

  always_ff @(posedge clk) begin
    if (internal_reset) begin
      state       <= S_IDLE;
      div_l       <= '0;
      depth_l     <= '0;
      presc_cnt   <= '0;
      wr_addr     <= '0;
      post_cnt    <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_trig_addr <= '0;
      o_wrapped   <= 1'b0;
    end else if (i_abort) begin
      // Abort wins over arm and run; the trigger address and wrap flag are kept for readout.
      state    <= S_IDLE;
      o_mem_we <= 1'b0;
    end else begin
      o_mem_we <= tick;
      if (tick) begin
        o_mem_addr  <= wr_addr;
        o_mem_wdata <= i_data;
        wr_addr     <= wr_addr + ADDR_W'(1);
      end
      if (run_state) begin
        presc_cnt <= tick ? '0 : presc_cnt + DIV_W'(1);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            state     <= S_ARMED;
            div_l     <= i_cfg_div;
            depth_l   <= i_cfg_depth;
            presc_cnt <= '0;
            wr_addr   <= '0;
            post_cnt  <= '0;
            o_wrapped <= 1'b0;
          end
        end
        S_ARMED: begin
`ifdef CAPTURE_PRETRIG_EN
          if (tick && (wr_addr == '1)) begin
            o_wrapped <= 1'b1;
          end
          if (i_run) begin
            // A tick in the trigger cycle is already the first post-trigger sample.
            o_trig_addr <= wr_addr;
            post_cnt    <= post_next;
            state       <= depth_hit ? S_DONE : S_CAPTURE;
          end
`else
          if (i_run) begin
            o_trig_addr <= '0;
            wr_addr     <= '0;
            presc_cnt   <= '0;
            post_cnt    <= '0;
            state       <= S_CAPTURE;
          end
`endif
        end
        S_CAPTURE: begin
          post_cnt <= post_next;
          if (depth_hit || !i_run) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
module tb_capture_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
`ifdef CAPTURE_PRETRIG_EN
  localparam bit PRETRIG = 1'b1;
`else
  localparam bit PRETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          internal_reset;
  logic [DW-1:0] i_cfg_div;
  logic [AW-1:0] i_cfg_depth;
  logic          i_arm, i_abort, i_run;
  logic [7:0]    i_data;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata;
  logic [AW-1:0] o_trig_addr;
  logic          o_wrapped, o_busy, o_done;
  logic [1:0]    o_state;

  int vectors = 0;
  int miscompares = 0;

  capture_sequencer #(.WIDTH(8), .ADDR_W(AW), .DIV_W(DW)) dut (
    .clk(clk), .internal_reset(internal_reset),
    .i_cfg_div(i_cfg_div), .i_cfg_depth(i_cfg_depth),
    .i_arm(i_arm), .i_abort(i_abort), .i_run(i_run), .i_data(i_data),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_trig_addr(o_trig_addr), .o_wrapped(o_wrapped), .o_busy(o_busy),
    .o_done(o_done), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    internal_reset = 1'b1; i_arm = 1'b0; i_abort = 1'b0; i_run = 1'b0;
    i_cfg_div = '0; i_cfg_depth = '0; i_data = '0;
    step(); step();
    vectors++; if (o_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", o_state); end
    vectors++; if (o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      miscompares++; $display("FAIL reset_mem got we=%0b addr=%0d data=%0h exp 0/0/0", o_mem_we, o_mem_addr, o_mem_wdata); end
    vectors++; if (o_trig_addr !== '0 || o_wrapped !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got trig=%0d wrap=%0b busy=%0b done=%0b exp all 0", o_trig_addr, o_wrapped, o_busy, o_done); end
    internal_reset = 1'b0;
    step();
  endtask

  // Reference: list of expected writes per active cycle k (k = 0 is the first ARMED cycle).
  // i_run is high for cycles pre .. pre+runlen-1.
  task automatic run_scenario(input string name, input int div, input int depth, input int pre, input int runlen);
    bit         ew[256];
    int         ea[256];
    logic [7:0] dat[256];
    int  depth_eff, tcount, post, kd, j, exp_trig;
    bit  tick, done, exp_wrap;
    depth_eff = (depth == 0) ? N : depth;
    tcount = 0; post = 0; kd = 250; done = 1'b0; exp_wrap = 1'b0; exp_trig = 0;
    for (int k = 0; k < 256; k++) begin
      dat[k] = 8'($urandom);
      ew[k] = 1'b0; ea[k] = 0;
      if (!done) begin
        j = PRETRIG ? k : k - pre - 1;
        tick = (j >= 0) && ((j % (div + 1)) == div);
        if (k == pre) exp_trig = PRETRIG ? (tcount % N) : 0;
        if (tick) begin
          ew[k] = 1'b1;
          ea[k] = tcount % N;
          if (k <= pre && (tcount % N) == N - 1) exp_wrap = 1'b1;
          tcount++;
          if (k >= pre) post++;
        end
        if (k >= pre && (post == depth_eff || k >= pre + runlen)) begin
          done = 1'b1; kd = k;
        end
      end
    end

    i_cfg_div = DW'(div); i_cfg_depth = AW'(depth); i_arm = 1'b1; i_run = 1'b0; i_data = 8'($urandom);
    step();
    vectors++; if (o_state !== 2'd1 || o_busy !== 1'b1) begin
      miscompares++; $display("FAIL %s arm got state=%0d busy=%0b exp 1/1", name, o_state, o_busy); end
    i_arm = 1'b0;
    i_cfg_div = DW'($urandom); i_cfg_depth = AW'($urandom);
    for (int k = 0; k <= kd + 3; k++) begin
      i_run = (k >= pre) && (k < pre + runlen);
      i_data = dat[k];
      step();
      vectors++; if (o_mem_we !== ew[k]) begin
        miscompares++; $display("FAIL %s we k=%0d got %0b exp %0b", name, k, o_mem_we, ew[k]); end
      if (ew[k]) begin
        vectors++; if (o_mem_addr !== AW'(ea[k]) || o_mem_wdata !== dat[k]) begin
          miscompares++; $display("FAIL %s write k=%0d got addr=%0d data=%0h exp addr=%0d data=%0h",
                                  name, k, o_mem_addr, o_mem_wdata, ea[k], dat[k]); end
      end
      if (k == kd) begin
        vectors++; if (o_state !== 2'd3) begin
          miscompares++; $display("FAIL %s done_edge k=%0d got state=%0d exp 3", name, k, o_state); end
      end
    end
    i_run = 1'b0;
    vectors++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_state !== 2'd3) begin
      miscompares++; $display("FAIL %s final got done=%0b busy=%0b state=%0d exp 1/0/3", name, o_done, o_busy, o_state); end
    vectors++; if (o_trig_addr !== AW'(exp_trig)) begin
      miscompares++; $display("FAIL %s trig_addr got %0d exp %0d", name, o_trig_addr, exp_trig); end
    vectors++; if (o_wrapped !== exp_wrap) begin
      miscompares++; $display("FAIL %s wrapped got %0b exp %0b", name, o_wrapped, exp_wrap); end
  endtask

  task automatic test_basic();
    run_scenario("basic", 0, 4, 6, 60);
  endtask

  task automatic test_prescale();
    run_scenario("prescale", 2, 5, 12, 60);
  endtask

  task automatic test_wrap();
    run_scenario("wrap", 0, 2, 18, 60);
  endtask

  task automatic test_run_fall();
    run_scenario("run_fall", 1, 12, 4, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_scenario($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 20)), int'($urandom_range(1, 30)));
    end
  endtask

  task automatic test_abort_reset();
    int exp_trig;
    exp_trig = PRETRIG ? 3 : 0;
    i_cfg_div = '0; i_cfg_depth = AW'(8); i_arm = 1'b1; i_run = 1'b0;
    step();
    i_arm = 1'b0;
    for (int k = 0; k < 3; k++) begin i_data = 8'($urandom); step(); end
    i_run = 1'b1; step();
    step();
    vectors++; if (o_state !== 2'd2) begin
      miscompares++; $display("FAIL abort_pre got state=%0d exp 2", o_state); end
    i_abort = 1'b1; i_arm = 1'b1;
    step();
    vectors++; if (o_state !== 2'd0 || o_mem_we !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort got state=%0d we=%0b busy=%0b exp 0/0/0", o_state, o_mem_we, o_busy); end
    vectors++; if (o_trig_addr !== AW'(exp_trig)) begin
      miscompares++; $display("FAIL abort_trig_hold got %0d exp %0d", o_trig_addr, exp_trig); end
    i_abort = 1'b0; i_arm = 1'b0;
    step();
    vectors++; if (o_state !== 2'd0 || o_mem_we !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle got state=%0d we=%0b exp 0/0", o_state, o_mem_we); end

    i_arm = 1'b1; i_run = 1'b0;
    step();
    i_arm = 1'b0; i_run = 1'b1;
    for (int k = 0; k < 3; k++) begin i_data = 8'($urandom); step(); end
    internal_reset = 1'b1;
    step();
    vectors++; if (o_state !== 2'd0 || o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      miscompares++; $display("FAIL reset_mid got state=%0d we=%0b addr=%0d data=%0h exp all 0", o_state, o_mem_we, o_mem_addr, o_mem_wdata); end
    vectors++; if (o_trig_addr !== '0 || o_wrapped !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_flags got trig=%0d wrap=%0b busy=%0b done=%0b exp all 0", o_trig_addr, o_wrapped, o_busy, o_done); end
    internal_reset = 1'b0; i_run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_wrap();
    test_run_fall();
    test_back_to_back();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
